mips_ifu: RTL and testbench
===========================

Name: mips_ifu

Overview:
Instruction-fetch unit for the multi-cycle MIPS core. It sits directly upstream of the controller and owns the PC, the next-PC selection and the IR. The unit is driven by the controller's pcwr, irwr and npcop outputs, and returns opcode/funct from the IR. Instruction memory is reached through a req/ack handshake with variable latency and a watchdog. While a fetch is in flight, fetch_busy holds the controller in S0.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset and base of the instruction-memory window
IM_AW, 10, instruction-memory word-address width
TIMEOUT, 16, maximum cycles to wait for imem_ack before aborting a fetch

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
pcwr  in  1  PC write enable from the controller
irwr  in  1  start an instruction fetch (controller S0)
npcop  in  2  next-PC select: 00 pc+4, 01 branch, 10 jump, 11 register
rs_data  in  32  GPR[rs], used as the target for jr/jalr
imem_req  out  1  fetch request
imem_addr  out  IM_AW  word address of the fetch
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word
ir  out  32  instruction register
opcode  out  6  ir[31:26]
funct  out  6  ir[5:0]
pc  out  32  current PC
pc_link  out  32  link value for jal/jalr, equal to pc (the PC has already advanced)
fetch_busy  out  1  fetch in flight
fetch_err  out  1  sticky: a fetch timed out
addr_err  out  1  sticky: misaligned jump-register target

Behaviour:
- Reset (rst low at a clock edge):
  - pc = RESET_PC; ir = 0; imem_req = 0; fetch_busy = 0; fetch_err = 0; addr_err = 0; FSM = IDLE; watchdog = 0.
  - Reset mid-fetch aborts the fetch. An ack arriving after the abort is ignored.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: irwr=1 → latch fa = pc, go to REQ. imem_req and fetch_busy rise on the following cycle.
  - REQ: imem_req=1, imem_addr = (fa - RESET_PC)[IM_AW+1:2].
    - imem_ack=1 → ir <= imem_rdata, go to IDLE.
    - Otherwise go to WAIT.
  - WAIT: imem_req stays 1 and the watchdog increments.
    - imem_ack → ir <= imem_rdata, go to IDLE.
    - Watchdog reaches TIMEOUT-1 without ack → ir <= 0 (nop), fetch_err <= 1, go to IDLE.
  - fetch_busy = (state != IDLE). It drops in the cycle after the ir load.
  - irwr while busy is ignored.
- Latency: the minimum from irwr to a valid ir is 2 edges (ack in REQ).
- PC update, on pcwr=1 only; the new value appears the next cycle:
  - npcop 00: pc+4.
  - npcop 01: pc + (sext(ir[15:0]) << 2). pc already points to the delay successor, so no extra +4 is added.
  - npcop 10: {pc[31:28], ir[25:0], 2'b00}.
  - npcop 11: {rs_data[31:2], 2'b00}. addr_err <= 1 if rs_data[1:0] != 0.
- All arithmetic is 32-bit modulo 2^32; wrap-around is silent.
- Simultaneous pcwr and irwr (S0): the fetch uses the pre-update pc, and pc becomes pc+4 at the same edge.
- pcwr during a fetch: the PC updates normally. The latched fa is unaffected.
- ir changes only on fetch completion or timeout. opcode and funct are combinational from ir.
- fetch_err and addr_err clear only on reset.

Decomposition:
- Shared package (mips_pkg):
  - NPC_PC4/NPC_BR/NPC_J/NPC_JR encodings, matching the controller's npcop.
  - RESET_PC default.
  - IFU FSM state encodings.
- One sub-module: mips_npc, the combinational next-PC mux (pc, ir, rs_data, npcop → npc, misalign).
- The FSM, watchdog, and PC/IR registers stay in mips_ifu.

Test Plan:
- Reset, then irwr with pcwr and ack on the first REQ cycle → imem_addr=0, ir=imem_rdata after 2 edges, pc=0x3004, fetch_busy high exactly 1 cycle.
- Ack delayed 5 cycles → imem_req held 5 cycles, ir loads on the ack cycle, fetch_err=0.
- No ack for TIMEOUT=16 cycles → ir=0, fetch_err=1, FSM returns to IDLE, a later ack is ignored.
- pc=0x3008, ir imm16=0xFFFE, npcop=01, pcwr → pc=0x3000. npcop=10 with ir[25:0]=0x0000C04 → pc=0x00003010.
- npcop=11, rs_data=0x300E, pcwr → pc=0x300C, addr_err=1, and it stays set through later fetches.
- rst low during WAIT → the next cycle shows imem_req=0, pc=0x3000, ir=0; a subsequent ack changes nothing.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS instruction-fetch unit
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'b00,
    IFU_REQ  = 2'b01,
    IFU_WAIT = 2'b10
  } ifu_state_e;

endpackage

// File: rtl/mips_npc.sv
// rtl/mips_npc.sv - combinational next-PC select and jump-register alignment check
module mips_npc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] rs_data,
  input  logic [1:0]  npcop,
  output logic [31:0] npc,
  output logic        misalign
);

  logic [5:0] unused_ir;
  assign unused_ir = ir[31:26];

  always_comb begin
    npc      = pc + 32'd4;
    misalign = 1'b0;
    case (npc_op_e'(npcop))
      NPC_PC4: npc = pc + 32'd4;
      // pc already holds the delay-slot successor, so the offset is added directly
      NPC_BR:  npc = pc + {{14{ir[15]}}, ir[15:0], 2'b00};
      NPC_J:   npc = {pc[31:28], ir[25:0], 2'b00};
      NPC_JR: begin
        npc      = {rs_data[31:2], 2'b00};
        misalign = |rs_data[1:0];
      end
      default: npc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/mips_ifu.sv
// rtl/mips_ifu.sv - PC/IR owner with handshaked, watchdog-guarded instruction fetch
module mips_ifu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_AW    = 10,
  parameter int          TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pcwr,
  input  logic             irwr,
  input  logic [1:0]       npcop,
  input  logic [31:0]      rs_data,
  output logic             imem_req,
  output logic [IM_AW-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic [31:0]      pc,
  output logic [31:0]      pc_link,
  output logic             fetch_busy,
  output logic             fetch_err,
  output logic             addr_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  ifu_state_e     state;
  logic [31:0]    fa;
  logic [31:0]    fa_off;
  logic [WDW-1:0] wdog;
  logic [31:0]    npc;
  logic           misalign;

  mips_npc u_npc (
    .pc       (pc),
    .ir       (ir),
    .rs_data  (rs_data),
    .npcop    (npcop),
    .npc      (npc),
    .misalign (misalign)
  );

  assign fa_off    = fa - RESET_PC;
  assign imem_addr = fa_off[IM_AW+1:2];
  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  assign pc_link   = pc;

  logic [31-IM_AW:0] unused_off;
  assign unused_off = {fa_off[31:IM_AW+2], fa_off[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IFU_IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      fa         <= RESET_PC;
      wdog       <= '0;
      imem_req   <= 1'b0;
      fetch_busy <= 1'b0;
      fetch_err  <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      if (pcwr) begin
        pc <= npc;
        if (misalign) addr_err <= 1'b1;
      end
      case (state)
        IFU_IDLE: begin
          // fa captures the pre-update pc even when pcwr fires on the same edge
          if (irwr) begin
            fa         <= pc;
            state      <= IFU_REQ;
            imem_req   <= 1'b1;
            fetch_busy <= 1'b1;
          end
        end
        IFU_REQ: begin
          if (imem_ack) begin
            ir         <= imem_rdata;
            state      <= IFU_IDLE;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
          end else begin
            state <= IFU_WAIT;
            wdog  <= WDW'(1);
          end
        end
        IFU_WAIT: begin
          if (imem_ack) begin
            ir         <= imem_rdata;
            state      <= IFU_IDLE;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            ir         <= '0;
            fetch_err  <= 1'b1;
            state      <= IFU_IDLE;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        default: begin
          state      <= IFU_IDLE;
          imem_req   <= 1'b0;
          fetch_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_ifu.sv
// tb/tb_mips_ifu.sv - scoreboard bench for mips_ifu fetch, PC update and reset abort
module tb_mips_ifu;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pcwr = 1'b0;
  logic        irwr = 1'b0;
  logic [1:0]  npcop = 2'b00;
  logic [31:0] rs_data = '0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_link;
  logic        fetch_busy;
  logic        fetch_err;
  logic        addr_err;

  mips_ifu #(.RESET_PC(32'h0000_3000), .IM_AW(10), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .pcwr       (pcwr),
    .irwr       (irwr),
    .npcop      (npcop),
    .rs_data    (rs_data),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .opcode     (opcode),
    .funct      (funct),
    .pc         (pc),
    .pc_link    (pc_link),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic        err;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A completed (or aborted) fetch is seen as the falling edge of fetch_busy
  initial begin : monitor
    logic prev_busy;
    int   busy_cnt;
    int   req_cnt;
    exp_t e;
    prev_busy = 1'b0;
    busy_cnt  = 0;
    req_cnt   = 0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) req_cnt++;
      if (fetch_busy === 1'b1) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fetch_end", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_ir", ir, e.ir);
          check("sb_fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
          check("sb_busy_cycles", busy_cnt, e.cycles);
          check("sb_req_cycles", req_cnt, e.cycles);
        end
        busy_cnt = 0;
        req_cnt  = 0;
      end
      prev_busy = (fetch_busy === 1'b1);
    end
  end

  // d = number of cycles imem_req is high; ack arrives in the last of them
  task automatic do_fetch(input int d, input logic [31:0] data, input logic pcw,
                          input logic [9:0] addr, input logic err);
    exp_t e;
    e.ir = data; e.err = err; e.cycles = d;
    exp_q.push_back(e);
    irwr = 1'b1; pcwr = pcw; npcop = NPC_PC4;
    tick();
    irwr = 1'b0; pcwr = 1'b0;
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", {22'd0, imem_addr}, {22'd0, addr});
    for (int i = 1; i <= d; i++) begin
      imem_ack   = (i == d);
      imem_rdata = (i == d) ? data : 32'hBAD0_0000;
      tick();
    end
    imem_ack = 1'b0;
  endtask

  task automatic pc_update(input logic [1:0] op, input logic [31:0] rs);
    pcwr = 1'b1; npcop = op; rs_data = rs;
    tick();
    pcwr = 1'b0; npcop = NPC_PC4;
  endtask

  initial begin : stim
    exp_t e;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_ir", ir, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_busy", {31'd0, fetch_busy}, 32'd0);
    check("rst_errs", {30'd0, fetch_err, addr_err}, 32'd0);

    // fast fetch with pcwr on the same edge
    do_fetch(1, 32'h8C01_0004, 1'b1, 10'd0, 1'b0);
    check("t1_pc", pc, 32'h0000_3004);
    check("t1_opcode", {26'd0, opcode}, 32'h23);

    // ack delayed: imem_req held 5 cycles, fetch from 0x3004
    do_fetch(5, 32'h1000_FFFE, 1'b1, 10'd1, 1'b0);
    check("t2_pc", pc, 32'h0000_3008);
    check("t2_fetch_err", {31'd0, fetch_err}, 32'd0);

    pc_update(NPC_BR, 32'h0);
    check("br_pc", pc, 32'h0000_3000);

    do_fetch(1, 32'h0800_0C04, 1'b0, 10'd0, 1'b0);
    pc_update(NPC_J, 32'h0);
    check("j_pc", pc, 32'h0000_3010);
    check("j_link", pc_link, 32'h0000_3010);

    pc_update(NPC_JR, 32'h0000_300E);
    check("jr_pc", pc, 32'h0000_300C);
    check("jr_addr_err", {31'd0, addr_err}, 32'd1);
    do_fetch(2, 32'h0000_0020, 1'b1, 10'd3, 1'b0);
    check("jr_addr_err_sticky", {31'd0, addr_err}, 32'd1);
    check("add_funct", {26'd0, funct}, 32'h20);
    check("pc4_after_jr", pc, 32'h0000_3010);

    // watchdog: no ack for 16 request cycles, fetch from 0x3010
    e.ir = 32'h0; e.err = 1'b1; e.cycles = 16;
    exp_q.push_back(e);
    irwr = 1'b1;
    tick();
    irwr = 1'b0;
    check("to_addr", {22'd0, imem_addr}, 32'd4);
    repeat (15) tick();
    check("to_busy_before", {31'd0, fetch_busy}, 32'd1);
    tick();
    check("to_ir", ir, 32'h0);
    check("to_fetch_err", {31'd0, fetch_err}, 32'd1);
    check("to_idle_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("late_ack_ir", ir, 32'h0);
    check("late_ack_busy", {31'd0, fetch_busy}, 32'd0);

    do_fetch(1, 32'h0128_4020, 1'b0, 10'd4, 1'b1);
    check("post_to_ir", ir, 32'h0128_4020);

    // reset during WAIT aborts the fetch and ignores a later ack
    e.ir = 32'h0; e.err = 1'b0; e.cycles = 4;
    exp_q.push_back(e);
    irwr = 1'b1;
    tick();
    irwr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rw_req", {31'd0, imem_req}, 32'd0);
    check("rw_pc", pc, 32'h0000_3000);
    check("rw_ir", ir, 32'h0);
    check("rw_errs", {30'd0, fetch_err, addr_err}, 32'd0);
    rst = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check("rw_ack_ir", ir, 32'h0);
    check("rw_ack_busy", {31'd0, fetch_busy}, 32'd0);

    tick(); tick();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
